// File: rtl/shifter_arbiter.sv
// Two-requester front end for one shared 32-bit barrel shifter: arbitrates one
// request per cycle onto the shifter ports and holds each result in a per-requester slot.

module shifter_arbiter_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        grant,
  input  logic        rsp_ready,
  input  logic [33:0] cap_data,
  output logic        rsp_valid,
  output logic [33:0] rsp_data
);
  logic        valid_q, valid_d;
  logic [33:0] data_q, data_d;

  // A grant in the same cycle as a drain keeps the slot full with fresh data.
  always_comb begin
    valid_d = grant | (valid_q & ~rsp_ready);
    data_d  = grant ? cap_data : data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rsp_valid = valid_q;
  assign rsp_data  = data_q;
endmodule

module shifter_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [4:0]  req0_b,
  input  logic [1:0]  req0_aluc,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [33:0] rsp0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [4:0]  req1_b,
  input  logic [1:0]  req1_aluc,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [33:0] rsp1_data,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_b,
  output logic [1:0]  sh_aluc,
  input  logic [31:0] sh_c,
  input  logic        sh_carry,
  input  logic        sh_negative
);
  localparam int NUM_LANES = 2;

  logic [NUM_LANES-1:0]        req_valid, rsp_ready, rsp_valid, elig, grant, grant_out;
  logic [NUM_LANES-1:0][31:0]  req_a;
  logic [NUM_LANES-1:0][4:0]   req_b;
  logic [NUM_LANES-1:0][1:0]   req_aluc;
  logic [NUM_LANES-1:0][33:0]  rsp_data;
  logic                        last_grant_q, last_grant_d;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_a     = {req1_a, req0_a};
  assign req_b     = {req1_b, req0_b};
  assign req_aluc  = {req1_aluc, req0_aluc};

  // A full slot is still eligible when its consumer drains it this cycle.
  assign elig = req_valid & (~rsp_valid | rsp_ready);

  always_comb begin
    grant = '0;
    if (elig[0] && (!elig[1] || (FIXED_PRIO != 0) || last_grant_q))
      grant[0] = 1'b1;
    else if (elig[1])
      grant[1] = 1'b1;
    last_grant_d = grant[1] ? 1'b1 : (grant[0] ? 1'b0 : last_grant_q);
  end

  // Slots are held in reset anyway; only the visible handshake and mux are masked.
  assign grant_out  = grant & {NUM_LANES{~rst}};
  assign req0_ready = grant_out[0];
  assign req1_ready = grant_out[1];

  always_comb begin
    sh_a    = '0;
    sh_b    = '0;
    sh_aluc = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (grant_out[i]) begin
        sh_a    = req_a[i];
        sh_b    = req_b[i];
        sh_aluc = req_aluc[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_grant_q <= 1'b1;
    else     last_grant_q <= last_grant_d;
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_slot
    shifter_arbiter_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .grant     (grant[i]),
      .rsp_ready (rsp_ready[i]),
      .cap_data  ({sh_negative, sh_carry, sh_c}),
      .rsp_valid (rsp_valid[i]),
      .rsp_data  (rsp_data[i])
    );
  end

  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp0_data  = rsp_data[0];
  assign rsp1_data  = rsp_data[1];
endmodule
